obi_mem_bist: RTL and testbench

OBI initiator that fills a word-aligned region of a memory bank with a deterministic pattern, reads it back, and compares. It is the master-side counterpart of the memory subsystem's OBI responder ports. One instance is connected per bank port and runs bring-up checks and power-gating/retention checks on the SRAM banks without involving the CPU.

---
 rtl/obi_mem_bist_pkg.sv | 19 +
 rtl/obi_pkg.sv | 18 +
 rtl/obi_mem_bist.sv | 178 +++++++++++++++++
 tb/tb_obi_mem_bist.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_mem_bist_pkg.sv
// Shared definitions for the OBI memory BIST initiator: FSM states and the data pattern.
package obi_mem_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWdrain,
    StRead,
    StRdrain,
    StDone
  } bist_state_e;

  localparam logic [3:0] BE_FULL = 4'hF;

  function automatic logic [31:0] bist_pattern(input logic [31:0] seed, input logic [31:0] addr);
    return seed ^ addr;
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response types shared by the memory subsystem's initiators and responders.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_mem_bist.sv
// OBI initiator that writes seed^addr over a word region, reads it back and counts mismatches.
module obi_mem_bist
  import obi_mem_bist_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [31:0]        base_addr_i,
  input  logic [CNT_W-1:0]   num_words_i,
  input  logic [31:0]        seed_i,
  output obi_pkg::obi_req_t  obi_req_o,
  input  obi_pkg::obi_resp_t obi_resp_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o,
  output logic [CNT_W-1:0]   err_count_o,
  output logic [31:0]        first_err_addr_o
);

  localparam int unsigned OutW = 4;

  bist_state_e      state_q, state_d;
  logic [31:0]      base_q, base_d, seed_q, seed_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]      first_err_q, first_err_d;
  logic [CNT_W-1:0] num_q, num_d, issue_q, issue_d, resp_q, resp_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [OutW-1:0]  outst_q, outst_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d;

  logic        req, fire, rsp, rd_rsp, in_run, start_ok;
  logic [31:0] base_cap, exp_addr;

  assign in_run   = (state_q == StWrite) || (state_q == StWdrain) ||
                    (state_q == StRead)  || (state_q == StRdrain);
  assign req      = ((state_q == StWrite) || (state_q == StRead)) && (issue_q < num_q) &&
                    (32'(outst_q) < MAX_OUTSTANDING);
  assign fire     = req & obi_resp_i.gnt;
  // Responses outside a run, or beyond what was granted, are stray and dropped.
  assign rsp      = obi_resp_i.rvalid && in_run && (outst_q != '0);
  assign rd_rsp   = rsp && ((state_q == StRead) || (state_q == StRdrain));
  assign start_ok = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign base_cap = base_addr_i & ~32'h3;
  assign exp_addr = base_q + (32'(resp_q) << 2);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    seed_d      = seed_q;
    num_d       = num_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    be_d        = be_q;
    issue_d     = issue_q;
    resp_d      = resp_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    outst_d     = outst_q + OutW'(fire) - OutW'(rsp);

    if (fire) begin
      issue_d = issue_q + CNT_W'(1);
      addr_d  = addr_q + 32'd4;
      wdata_d = bist_pattern(seed_q, addr_q + 32'd4);
    end

    if (rd_rsp) begin
      resp_d = resp_q + CNT_W'(1);
      if (obi_resp_i.rdata != bist_pattern(seed_q, exp_addr)) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (err_cnt_q == '0) first_err_d = exp_addr;
      end
    end

    case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          base_d      = base_cap;
          seed_d      = seed_i;
          num_d       = num_words_i;
          issue_d     = '0;
          resp_d      = '0;
          outst_d     = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
          if (num_words_i == '0) begin
            state_d = StDone;
          end else begin
            state_d = StWrite;
            addr_d  = base_cap;
            wdata_d = bist_pattern(seed_i, base_cap);
            we_d    = 1'b1;
            be_d    = BE_FULL;
          end
        end
      end
      StWrite: if (fire && (issue_d == num_q)) state_d = StWdrain;
      StWdrain: begin
        // Leave as soon as the last write response lands, so reads start one cycle later.
        if (outst_d == '0) begin
          state_d = StRead;
          issue_d = '0;
          addr_d  = base_q;
          wdata_d = '0;
          we_d    = 1'b0;
        end
      end
      StRead: if (fire && (issue_d == num_q)) state_d = StRdrain;
      // Waits on the registered count: the final compare is already in err_cnt_q on exit.
      StRdrain: if (outst_q == '0) state_d = StDone;
      default: state_d = StIdle;
    endcase

    busy_d  = (state_d == StWrite) || (state_d == StWdrain) ||
              (state_d == StRead)  || (state_d == StRdrain);
    done_d  = (state_d == StDone);
    error_d = (err_cnt_d != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      base_q      <= '0;
      seed_q      <= '0;
      num_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      issue_q     <= '0;
      resp_q      <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      outst_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      seed_q      <= seed_d;
      num_q       <= num_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      be_q        <= be_d;
      issue_q     <= issue_d;
      resp_q      <= resp_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      outst_q     <= outst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    obi_req_o       = '0;
    obi_req_o.req   = req;
    obi_req_o.we    = we_q;
    obi_req_o.be    = be_q;
    obi_req_o.addr  = addr_q;
    obi_req_o.wdata = wdata_q;
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign err_count_o      = err_cnt_q;
  assign first_err_addr_o = first_err_q;

endmodule

// File: tb/tb_obi_mem_bist.sv
// Scoreboard bench for obi_mem_bist: a memory responder model plus queued expected requests/results.
module tb_obi_mem_bist;
  import obi_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_req_t;

  typedef struct packed {
    logic [15:0] err_count;
    logic [31:0] first_err;
    logic        error;
    logic [31:0] lat;
  } exp_res_t;

  typedef struct packed {
    logic [31:0] due;
    logic [31:0] rdata;
  } pend_t;

  logic        clk, rst, start;
  logic [31:0] base, seed;
  logic [15:0] num;
  obi_req_t    req;
  obi_resp_t   resp;
  logic        busy, done, error;
  logic [15:0] err_count;
  logic [31:0] first_err;

  logic        s_start;
  obi_req_t    s_req;
  obi_resp_t   s_resp;
  logic        s_busy, s_done, s_error, s_rvalid, s_prev;
  logic [3:0]  s_err_count;
  logic [31:0] s_first_err;

  int checks = 0;
  int errors = 0;

  exp_req_t exp_req_q[$];
  exp_res_t exp_res_q[$];
  pend_t    pend_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] tbl_a[4];
  logic [31:0] tbl_d[4];

  int          ncyc = 0;
  int          t0 = 0;
  int          rv_delay = 1;
  int          corrupt_idx = -1;
  int          bp_word = -1;
  int          wr_cnt = 0, rd_cnt = 0, hold = 0, outst = 0;
  logic        gnt_block, rvalid_r, prev_stall, done_prev;
  logic [31:0] rdata_r;
  obi_req_t    snap;

  obi_mem_bist #(.MAX_OUTSTANDING(2), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .num_words_i(num),
    .seed_i(seed), .obi_req_o(req), .obi_resp_i(resp), .busy_o(busy), .done_o(done),
    .error_o(error), .err_count_o(err_count), .first_err_addr_o(first_err)
  );

  obi_mem_bist #(.MAX_OUTSTANDING(1), .CNT_W(4)) u_sat (
    .clk_i(clk), .rst_i(rst), .start_i(s_start), .base_addr_i(32'h0000_1000),
    .num_words_i(4'd15), .seed_i(32'h1234_5678), .obi_req_o(s_req), .obi_resp_i(s_resp),
    .busy_o(s_busy), .done_o(s_done), .error_o(s_error), .err_count_o(s_err_count),
    .first_err_addr_o(s_first_err)
  );

  always_comb begin
    resp        = '0;
    resp.gnt    = req.req & ~gnt_block;
    resp.rvalid = rvalid_r;
    resp.rdata  = rdata_r;
    s_resp        = '0;
    s_resp.gnt    = s_req.req;
    s_resp.rvalid = s_rvalid;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Responder, request scoreboard and result monitor, all evaluated mid-cycle.
  initial begin
    pend_t    p;
    exp_req_t e;
    exp_res_t r;
    logic     hs;
    logic [31:0] d;
    gnt_block = 1'b0; rvalid_r = 1'b0; rdata_r = '0; prev_stall = 1'b0; done_prev = 1'b0;
    s_rvalid = 1'b0; s_prev = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        pend_q.delete(); exp_req_q.delete(); exp_res_q.delete();
        outst = 0; gnt_block = 1'b0; rvalid_r = 1'b0; rdata_r = '0;
        prev_stall = 1'b0; done_prev = 1'b0; s_rvalid = 1'b0; s_prev = 1'b0;
      end else begin
        s_rvalid = s_prev;
        s_prev   = s_req.req;
        if (start && !busy) begin
          t0 = ncyc; wr_cnt = 0; rd_cnt = 0; hold = 0;
        end
        rvalid_r = 1'b0;
        rdata_r  = '0;
        if (pend_q.size() != 0 && pend_q[0].due == 32'(ncyc)) begin
          p = pend_q.pop_front();
          rvalid_r = 1'b1;
          rdata_r  = p.rdata;
        end
        gnt_block = 1'b0;
        if (req.req && req.we && wr_cnt == bp_word && hold < 3) begin
          gnt_block = 1'b1;
          hold++;
        end
        hs = req.req && !gnt_block;
        if (prev_stall) begin
          check("stall_req", 32'(req.req), 32'd1);
          check("stall_addr", req.addr, snap.addr);
          check("stall_wdata", req.wdata, snap.wdata);
          check("stall_be", 32'(req.be), 32'(snap.be));
        end
        prev_stall = req.req && !hs;
        snap = req;
        if (hs) begin
          if (exp_req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: got addr %h we %0d, required none", req.addr, req.we);
          end else begin
            e = exp_req_q.pop_front();
            check("req_we", 32'(req.we), 32'(e.we));
            check("req_addr", req.addr, e.addr);
            check("req_be", 32'(req.be), 32'hF);
            if (e.we) check("req_wdata", req.wdata, e.wdata);
          end
          if (req.we) begin
            mem[req.addr] = req.wdata;
            d = '0;
            wr_cnt++;
          end else begin
            d = mem.exists(req.addr) ? mem[req.addr] : 32'hDEAD_BEEF;
            if (rd_cnt == corrupt_idx) d = d ^ 32'h1;
            rd_cnt++;
          end
          pend_q.push_back('{due: 32'(ncyc + rv_delay), rdata: d});
        end
        outst = outst + int'(hs) - int'(rvalid_r);
        if (hs) check("max_outstanding", 32'(outst <= 2), 32'd1);
        if (done && !done_prev) begin
          if (exp_res_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done at cycle %0d, required none", ncyc - t0);
          end else begin
            r = exp_res_q.pop_front();
            check("done_latency", 32'(ncyc - t0), r.lat);
            check("err_count", 32'(err_count), 32'(r.err_count));
            check("first_err_addr", first_err, r.first_err);
            check("error_o", 32'(error), 32'(r.error));
            check("reqs_missing", 32'(exp_req_q.size()), 32'd0);
          end
        end
        done_prev = done;
      end
    end
  end

  task automatic push_word(input logic [31:0] a, input logic [31:0] dat, input int k, input int n);
    exp_req_q.insert(k, '{we: 1'b1, addr: a, wdata: dat});
    exp_req_q.push_back('{we: 1'b0, addr: a, wdata: '0});
    if (k == n - 1) begin end
  endtask

  task automatic push_formula(input logic [31:0] b, input int n, input logic [31:0] s);
    int base_idx;
    base_idx = exp_req_q.size();
    for (int k = 0; k < n; k++) push_word(b + 32'(4 * k), s ^ (b + 32'(4 * k)), base_idx + k, n);
  endtask

  task automatic push_table();
    int base_idx;
    base_idx = exp_req_q.size();
    for (int k = 0; k < 4; k++) push_word(tbl_a[k], tbl_d[k], base_idx + k, 4);
  endtask

  task automatic push_result(input logic [15:0] ec, input logic [31:0] fe, input int lat);
    exp_res_q.push_back('{err_count: ec, first_err: fe, error: (ec != 0), lat: 32'(lat)});
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s);
    @(posedge clk); #1;
    start = 1'b1; base = b; num = n; seed = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (exp_res_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_res_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done after %0d cycles, required done", name, n);
      exp_res_q.delete();
      exp_req_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; base = '0; num = '0; seed = '0; s_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(req.req), 32'd0);
    check("rst_we", 32'(req.we), 32'd0);
    check("rst_be", 32'(req.be), 32'd0);
    check("rst_addr", req.addr, 32'd0);
    check("rst_wdata", req.wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_first_err", first_err, 32'd0);
    rst = 1'b0;

    // N=0 from IDLE: done the cycle after start, no request.
    push_result(16'd0, 32'd0, 1);
    pulse_start(32'h8000_0000, 16'd0, 32'h1111_1111);
    wait_done("n0");

    tbl_a = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C};
    tbl_d = '{32'h25A5_0000, 32'h25A5_0004, 32'h25A5_0008, 32'h25A5_000C};
    push_table();
    push_result(16'd0, 32'd0, 12);
    pulse_start(32'h8000_0000, 16'd4, 32'hA5A5_0000);
    wait_done("basic");

    corrupt_idx = 2;
    push_table();
    push_result(16'd1, 32'h8000_0008, 12);
    pulse_start(32'h8000_0000, 16'd4, 32'hA5A5_0000);
    wait_done("fault");
    corrupt_idx = -1;

    bp_word = 1;
    push_formula(32'h0000_0100, 4, 32'h1357_9BDF);
    push_result(16'd0, 32'd0, 15);
    pulse_start(32'h0000_0103, 16'd4, 32'h1357_9BDF);
    wait_done("backpressure");
    bp_word = -1;

    rv_delay = 3;
    push_formula(32'h0000_2000, 4, 32'hCAFE_F00D);
    push_result(16'd0, 32'd0, 20);
    pulse_start(32'h0000_2000, 16'd4, 32'hCAFE_F00D);
    wait_done("outstanding");
    rv_delay = 1;

    // A second start while busy must not disturb the run in flight.
    push_formula(32'h0000_0300, 4, 32'h0BAD_CAFE);
    push_result(16'd0, 32'd0, 12);
    pulse_start(32'h0000_0300, 16'd4, 32'h0BAD_CAFE);
    check("busy_mid_run", 32'(busy), 32'd1);
    pulse_start(32'h0000_9000, 16'd1, 32'hFFFF_0000);
    wait_done("start_busy");

    tbl_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    tbl_d = '{32'hF0F0_F0F7, 32'hF0F0_F0F3, 32'h0F0F_0F0F, 32'h0F0F_0F0B};
    push_table();
    push_result(16'd0, 32'd0, 12);
    pulse_start(32'hFFFF_FFF8, 16'd4, 32'h0F0F_0F0F);
    wait_done("wrap");

    corrupt_idx = 0;
    push_formula(32'h0000_0400, 8, 32'h5555_AAAA);
    push_result(16'd1, 32'h0000_0400, 20);
    pulse_start(32'h0000_0400, 16'd8, 32'h5555_AAAA);
    n = 0;
    while (rd_cnt < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("reached_read", 32'(rd_cnt >= 2), 32'd1);
    @(posedge clk); #1;
    check("pre_rst_error", 32'(error), 32'd1);
    rst = 1'b1;
    #2;
    check("mid_rst_req", 32'(req.req), 32'd0);
    check("mid_rst_addr", req.addr, 32'd0);
    check("mid_rst_wdata", req.wdata, 32'd0);
    check("mid_rst_be", 32'(req.be), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    check("mid_rst_first_err", first_err, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    corrupt_idx = -1;
    repeat (4) @(posedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    tbl_a = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C};
    tbl_d = '{32'h25A5_0000, 32'h25A5_0004, 32'h25A5_0008, 32'h25A5_000C};
    push_table();
    push_result(16'd0, 32'd0, 12);
    pulse_start(32'h8000_0000, 16'd4, 32'hA5A5_0000);
    wait_done("after_reset");

    // Every read wrong on a 4-bit counter, one request per two cycles.
    @(posedge clk); #1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    n = 1;
    while (!s_done && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("sat_latency", 32'(n), 32'd62);
    check("sat_err_count", 32'(s_err_count), 32'hF);
    check("sat_error", 32'(s_error), 32'd1);
    check("sat_first_err", s_first_err, 32'h0000_1000);
    check("sat_busy", 32'(s_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
